// File: rtl/rtl_kernel_wizard_1_example_number_checker.sv
// AXI4-Stream sink that checks the incrementing-number pattern of the example
// generator: per-lane data, tkeep and tlast, with a sticky error summary.

module rtl_kernel_wizard_1_example_number_checker_lane #(
    parameter int NW   = 32,
    parameter int LANE = 0
) (
    input  logic [NW-1:0]   data,
    input  logic [NW/8-1:0] keep,
    input  logic [NW-1:0]   cnt_field,
    output logic            mismatch
);
    logic [NW-1:0] expected;
    logic [NW-1:0] mask;

    assign expected = cnt_field | NW'(LANE);

    for (genvar b = 0; b < NW/8; b++) begin : g_mask
        assign mask[b*8 +: 8] = {8{keep[b]}};
    end

    // Bytes outside the expected keep are don't-care.
    assign mismatch = |((data ^ expected) & mask);
endmodule

module rtl_kernel_wizard_1_example_number_checker #(
    parameter int C_S_AXIS_TDATA_WIDTH = 128,
    parameter int C_NUMBER_BIT_WIDTH   = 32,
    parameter int C_LENGTH_IN_BYTES    = 16384
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              ap_start,
    output logic                              ap_done,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                              s_axis_tlast,
    output logic                              error,
    output logic [31:0]                       error_count,
    output logic [31:0]                       first_error_beat
);
    localparam int TDW       = C_S_AXIS_TDATA_WIDTH;
    localparam int LP_NW     = (C_NUMBER_BIT_WIDTH > TDW) ? TDW : C_NUMBER_BIT_WIDTH;
    localparam int NG        = TDW / LP_NW;
    localparam int SB        = (NG > 1) ? $clog2(NG) : 0;
    localparam int LB        = LP_NW / 8;
    localparam int BPB       = TDW / 8;
    localparam int NUM_BEATS = (C_LENGTH_IN_BYTES + BPB - 1) / BPB;
    localparam int REM       = C_LENGTH_IN_BYTES % BPB;

    localparam logic [BPB-1:0] KEEP_ALL   = '1;
    localparam logic [BPB-1:0] FINAL_KEEP = (REM == 0) ? KEEP_ALL : (KEEP_ALL >> (BPB - REM));
    localparam logic [31:0]    LAST_BEAT  = 32'(NUM_BEATS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic            ap_start_r;
    logic [31:0]     beat_cnt;
    logic            go;
    logic            is_last;
    logic            handshake;
    logic            beat_bad;
    logic [BPB-1:0]  exp_keep;
    logic [LP_NW-1:0] cnt_field;
    logic [NG-1:0]   lane_bad;

    assign go        = ap_start & ~ap_start_r;
    assign is_last   = (beat_cnt == LAST_BEAT);
    assign handshake = s_axis_tvalid & s_axis_tready;
    assign exp_keep  = is_last ? FINAL_KEEP : KEEP_ALL;

    // The shift drops the upper SB bits of the count, so the pattern wraps at 2^(LP_NW-SB).
    assign cnt_field = LP_NW'(beat_cnt) << SB;

    for (genvar n = 0; n < NG; n++) begin : g_lane
        rtl_kernel_wizard_1_example_number_checker_lane #(
            .NW   (LP_NW),
            .LANE (n)
        ) u_lane (
            .data      (s_axis_tdata[n*LP_NW +: LP_NW]),
            .keep      (exp_keep[n*LB +: LB]),
            .cnt_field (cnt_field),
            .mismatch  (lane_bad[n])
        );
    end

    assign beat_bad = (|lane_bad) | (s_axis_tkeep != exp_keep) | (s_axis_tlast != is_last);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state            <= IDLE;
            ap_start_r       <= 1'b0;
            s_axis_tready    <= 1'b0;
            ap_done          <= 1'b0;
            error            <= 1'b0;
            error_count      <= '0;
            first_error_beat <= '1;
            beat_cnt         <= '0;
        end else begin
            ap_start_r <= ap_start;
            ap_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        error            <= 1'b0;
                        error_count      <= '0;
                        first_error_beat <= '1;
                        beat_cnt         <= '0;
                        s_axis_tready    <= 1'b1;
                        state            <= RUN;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (beat_bad) begin
                            error <= 1'b1;
                            if (error_count != '1)
                                error_count <= error_count + 32'd1;
                            if (first_error_beat == '1)
                                first_error_beat <= beat_cnt;
                        end
                        beat_cnt <= beat_cnt + 32'd1;
                        // Early tlast or the last expected beat, whichever comes first.
                        if (s_axis_tlast || is_last) begin
                            s_axis_tready <= 1'b0;
                            ap_done       <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rtl_kernel_wizard_1_example_number_checker.sv
// Bench for the number checker: a default-length instance and a 40-byte
// instance share one stream source; a behavioural model predicts every cycle.

module tb_rtl_kernel_wizard_1_example_number_checker;
    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         st0 = 1'b0, st1 = 1'b0;
    logic         tvalid = 1'b0, tlast = 1'b0;
    logic [127:0] tdata = '0;
    logic [15:0]  tkeep = '0;
    logic         r0, d0, e0, r1, d1, e1;
    logic [31:0]  c0, f0, c1, f1;

    always #5 aclk = ~aclk;

    rtl_kernel_wizard_1_example_number_checker dut0 (
        .aclk(aclk), .aresetn(aresetn), .ap_start(st0), .ap_done(d0),
        .s_axis_tvalid(tvalid), .s_axis_tready(r0), .s_axis_tdata(tdata),
        .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .error(e0),
        .error_count(c0), .first_error_beat(f0));

    rtl_kernel_wizard_1_example_number_checker #(.C_LENGTH_IN_BYTES(40)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .ap_start(st1), .ap_done(d1),
        .s_axis_tvalid(tvalid), .s_axis_tready(r1), .s_axis_tdata(tdata),
        .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .error(e1),
        .error_count(c1), .first_error_beat(f1));

    bit sel = 1'b0;
    logic        rdy, done, err;
    logic [31:0] cnt, first;
    assign rdy   = sel ? r1 : r0;
    assign done  = sel ? d1 : d0;
    assign err   = sel ? e1 : e0;
    assign cnt   = sel ? c1 : c0;
    assign first = sel ? f1 : f0;

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Stimulus knobs for one run.
    int          g_nsend, g_last_at, g_corrupt_k, g_corrupt_lane, g_gap, g_pulse_at, g_abort_at;
    logic [31:0] g_corrupt_val;
    logic [15:0] g_final_keep, g_garbage;

    function automatic int cfg_nb();
        return sel ? 3 : 1024;
    endfunction
    function automatic logic [15:0] cfg_fk();
        return sel ? 16'h00FF : 16'hFFFF;
    endfunction

    // Model: a beat is bad if any kept byte differs from the number pattern,
    // if tkeep is not the expected keep, or if tlast is misplaced.
    function automatic bit beat_bad(longint k, int nb, logic [15:0] fk,
                                    logic [127:0] d, logic [15:0] kp, logic lst);
        bit          bad = 0;
        bit          last = (k == longint'(nb - 1));
        logic [15:0] ek = last ? fk : 16'hFFFF;
        longint      v;
        if (kp != ek) bad = 1;
        if (lst != last) bad = 1;
        for (int b = 0; b < 16; b++) begin
            if (ek[b]) begin
                v = (k % (longint'(1) << 30)) * 4 + longint'(b / 4);
                if (longint'(d[b*8 +: 8]) != ((v >> (8 * (b % 4))) & 255)) bad = 1;
            end
        end
        return bad;
    endfunction

    int          m_state;   // 0 idle, 1 accepting, 2 done pulse
    bit          m_start_r, m_err;
    logic [31:0] m_cnt, m_first;
    longint      m_k;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_state = 0; m_start_r = 0; m_err = 0; m_cnt = 0; m_first = 32'hFFFFFFFF; m_k = 0;
        end else begin
            bit cur, go;
            cur = sel ? st1 : st0;
            go = cur && !m_start_r;
            m_start_r = cur;
            case (m_state)
                0: if (go) begin
                    m_err = 0; m_cnt = 0; m_first = 32'hFFFFFFFF; m_k = 0; m_state = 1;
                end
                1: if (tvalid) begin
                    if (beat_bad(m_k, cfg_nb(), cfg_fk(), tdata, tkeep, tlast)) begin
                        m_err = 1;
                        if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
                        if (m_first == 32'hFFFFFFFF) m_first = 32'(m_k);
                    end
                    if (tlast || m_k == longint'(cfg_nb() - 1)) m_state = 2;
                    m_k++;
                end
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge aclk) begin
        if (chk_en) begin
            chk("tready", {31'd0, rdy}, {31'd0, m_state == 1});
            chk("ap_done", {31'd0, done}, {31'd0, m_state == 2});
            chk("error", {31'd0, err}, {31'd0, m_err});
            chk("error_count", cnt, m_cnt);
            chk("first_error_beat", first, m_first);
        end
    end

    task automatic set_defaults();
        g_nsend = cfg_nb(); g_last_at = cfg_nb() - 1; g_corrupt_k = -1; g_corrupt_lane = 0;
        g_corrupt_val = 0; g_final_keep = cfg_fk(); g_garbage = 16'h0000; g_gap = 0;
        g_pulse_at = -1; g_abort_at = -1;
    endtask

    task automatic pulse_start(input logic v);
        if (sel) st1 = v; else st0 = v;
    endtask

    task automatic send_beats();
        logic [31:0]  kk;
        logic [127:0] d;
        bit           hs;
        int           t;
        for (int k = 0; k < g_nsend; k++) begin
            if (k == g_abort_at) begin
                tvalid = 0; aresetn = 0;
                @(posedge aclk); #1;
                @(posedge aclk); #1;
                aresetn = 1;
                return;
            end
            if (k == g_pulse_at) begin
                tvalid = 0; pulse_start(1);
                @(posedge aclk); #1;
                pulse_start(0);
            end
            if ($urandom_range(0, 99) < g_gap) begin
                tvalid = 0; tdata = {$urandom, $urandom, $urandom, $urandom}; tlast = 1;
                @(posedge aclk); #1;
            end
            kk = 32'(k);
            for (int n = 0; n < 4; n++) d[n*32 +: 32] = {kk[29:0], 2'(n)};
            if (k == g_corrupt_k) d[g_corrupt_lane*32 +: 32] = g_corrupt_val;
            tkeep = 16'hFFFF;
            if (k == cfg_nb() - 1) begin
                tkeep = g_final_keep;
                for (int b = 0; b < 16; b++)
                    if (g_garbage[b]) d[b*8 +: 8] = 8'hA5 ^ 8'(b);
            end
            tdata = d; tlast = (k == g_last_at); tvalid = 1;
            hs = 0; t = 0;
            while (!hs && t < 50) begin
                @(negedge aclk); hs = rdy;
                @(posedge aclk); #1;
                t++;
            end
            if (!hs) begin
                chk("handshake_timeout", 32'd0, 32'd1);
                break;
            end
        end
        tvalid = 0; tlast = 0;
    endtask

    task automatic run_case(input string name, input bit exp_done, input bit ee,
                            input logic [31:0] ec, input logic [31:0] ef);
        bit seen = 0;
        pulse_start(1);
        @(posedge aclk); #1;
        pulse_start(0);
        send_beats();
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            seen = done;
        end
        chk({name, "_done_seen"}, {31'd0, seen}, {31'd0, exp_done});
        chk({name, "_error"}, {31'd0, err}, {31'd0, ee});
        chk({name, "_count"}, cnt, ec);
        chk({name, "_first"}, first, ef);
        @(posedge aclk); #1;
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tready", {31'd0, r0}, 32'd0);
        chk("rst_done", {31'd0, d0}, 32'd0);
        chk("rst_error", {31'd0, e0}, 32'd0);
        chk("rst_count", c0, 32'd0);
        chk("rst_first", f0, 32'hFFFFFFFF);
        aresetn = 1; chk_en = 1;
        @(posedge aclk); #1;

        set_defaults();
        run_case("clean", 1, 0, 0, 32'hFFFFFFFF);

        set_defaults(); g_corrupt_k = 5; g_corrupt_lane = 2; g_corrupt_val = 32'h17;
        run_case("corrupt5", 1, 1, 1, 5);

        set_defaults(); g_nsend = 100; g_last_at = 99;
        run_case("early_tlast", 1, 1, 1, 99);

        set_defaults(); g_last_at = -1;
        run_case("missing_tlast", 1, 1, 1, 1023);

        set_defaults(); g_gap = 50; g_pulse_at = 400;
        run_case("gaps", 1, 0, 0, 32'hFFFFFFFF);

        set_defaults(); g_abort_at = 300;
        run_case("abort", 0, 0, 0, 32'hFFFFFFFF);

        set_defaults();
        run_case("after_abort", 1, 0, 0, 32'hFFFFFFFF);

        aresetn = 0;
        @(posedge aclk); #1;
        sel = 1;
        @(posedge aclk); #1;
        aresetn = 1;
        @(posedge aclk); #1;

        set_defaults(); g_garbage = 16'hFF00;
        run_case("short_keep", 1, 0, 0, 32'hFFFFFFFF);

        set_defaults(); g_garbage = 16'hFF00; g_final_keep = 16'hFFFF;
        run_case("short_badkeep", 1, 1, 1, 2);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
